// File: rtl/instruction_register_if.sv
// Instruction register bus bundle.
// Control-side signals in, opcode/operand/status out.
interface instruction_register_if #(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 4
);
    logic [DATA_W-1:0]          bus_in;
    logic                       ir_load;
    logic                       ir_out;
    logic                       ir_clr;
    logic [OPCODE_W-1:0]        opcode;
    logic [DATA_W-OPCODE_W-1:0] operand;
    logic                       operand_oe;
    logic                       ir_valid;
    logic                       halted;
    logic [7:0]                 fetch_count;

    modport master (
        output bus_in,
        output ir_load,
        output ir_out,
        output ir_clr,
        input  opcode,
        input  operand,
        input  operand_oe,
        input  ir_valid,
        input  halted,
        input  fetch_count
    );

    modport slave (
        input  bus_in,
        input  ir_load,
        input  ir_out,
        input  ir_clr,
        output opcode,
        output operand,
        output operand_oe,
        output ir_valid,
        output halted,
        output fetch_count
    );
endinterface

// File: rtl/instruction_register.sv
// Instruction register: captures the fetched byte, exposes opcode,
// drives the operand nibble on request, latches a sticky halt.
module instruction_register #(
    parameter int                  DATA_W     = 8,
    parameter int                  OPCODE_W   = 4,
    parameter logic [OPCODE_W-1:0] HLT_OPCODE = 4'hF,
    parameter logic [OPCODE_W-1:0] NOP_OPCODE = 4'h0
) (
    input logic                     clk,
    input logic                     rst_n,
    instruction_register_if.slave   ir_bus
);
    localparam int OPER_W = DATA_W - OPCODE_W;

    logic [DATA_W-1:0] ir_q;
    logic              valid_q;
    logic              halted_q;
    logic [7:0]        count_q;
    logic [OPCODE_W-1:0] load_opc;

    assign load_opc = ir_bus.bus_in[DATA_W-1 -: OPCODE_W];

    // Held instruction, halt flag and fetch counter; halt freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 8'd0;
        end else if (halted_q) begin
            ir_q     <= ir_q;
        end else if (ir_bus.ir_clr) begin
            ir_q     <= '0;
            valid_q  <= 1'b0;
        end else if (ir_bus.ir_load) begin
            ir_q     <= ir_bus.bus_in;
            valid_q  <= 1'b1;
            count_q  <= count_q + 8'd1;
            if (load_opc == HLT_OPCODE)
                halted_q <= 1'b1;
        end
    end

    // Opcode and operand presentation derived from held state.
    always_comb begin
        ir_bus.opcode     = NOP_OPCODE;
        ir_bus.operand    = '0;
        ir_bus.operand_oe = ir_bus.ir_out & valid_q;
        if (valid_q)
            ir_bus.opcode = ir_q[DATA_W-1 -: OPCODE_W];
        if (ir_bus.operand_oe)
            ir_bus.operand = ir_q[OPER_W-1:0];
    end

    assign ir_bus.ir_valid    = valid_q;
    assign ir_bus.halted      = halted_q;
    assign ir_bus.fetch_count = count_q;
endmodule

// File: tb/tb_instruction_register.sv
// Directed scoreboard bench for instruction_register.
// Expected outputs are queued from a reference model and popped on check.
module tb_instruction_register;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    instruction_register_if irb ();

    instruction_register dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ir_bus (irb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc;
        logic [3:0] opd;
        logic       oe;
        logic       v;
        logic       h;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_eval = 0;
    int   n_fail = 0;

    logic [7:0] m_ir;
    logic       m_valid;
    logic       m_halted;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_ir = 8'h00;
        m_valid = 1'b0;
        m_halted = 1'b0;
        m_cnt = 8'd0;
    endtask

    task automatic model_edge(input logic ld, input logic cl, input logic [7:0] b);
        if (m_halted) begin
        end else if (cl) begin
            m_ir = 8'h00;
            m_valid = 1'b0;
        end else if (ld) begin
            m_ir = b;
            m_valid = 1'b1;
            m_cnt = m_cnt + 8'd1;
            if (b[7:4] == 4'hF) m_halted = 1'b1;
        end
    endtask

    task automatic push_exp(input logic out, input string tag);
        exp_t e;
        e.opc = m_valid ? m_ir[7:4] : 4'h0;
        e.oe  = out & m_valid;
        e.opd = e.oe ? m_ir[3:0] : 4'h0;
        e.v   = m_valid;
        e.h   = m_halted;
        e.cnt = m_cnt;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic chk1(input string tag, input string f, input logic [7:0] obs, input logic [7:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        n_eval++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk1(e.tag, "opcode", {4'h0, irb.opcode}, {4'h0, e.opc});
            chk1(e.tag, "operand", {4'h0, irb.operand}, {4'h0, e.opd});
            chk1(e.tag, "oe", {7'h0, irb.operand_oe}, {7'h0, e.oe});
            chk1(e.tag, "valid", {7'h0, irb.ir_valid}, {7'h0, e.v});
            chk1(e.tag, "halted", {7'h0, irb.halted}, {7'h0, e.h});
            chk1(e.tag, "count", irb.fetch_count, e.cnt);
        end
    endtask

    // Drive one cycle: check comb outputs before the edge, then advance model.
    task automatic step(input logic ld, input logic cl, input logic out,
                        input logic [7:0] b, input string tag);
        @(negedge clk);
        irb.ir_load = ld;
        irb.ir_clr  = cl;
        irb.ir_out  = out;
        irb.bus_in  = b;
        #1;
        push_exp(out, tag);
        check();
        @(posedge clk);
        model_edge(ld, cl, b);
    endtask

    // Reset pulse strictly between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        push_exp(irb.ir_out, tag);
        check();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        irb.ir_load = 1'b0;
        irb.ir_clr  = 1'b0;
        irb.ir_out  = 1'b1;
        irb.bus_in  = 8'h00;
        model_reset();
        #2;
        push_exp(1'b1, "reset");
        check();
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 1, 8'h00, "out_no_valid");
        step(1, 0, 0, 8'h2A, "load_2A");
        step(0, 0, 1, 8'h00, "after_2A");
        chk1("after_2A_const", "operand", {4'h0, irb.operand}, 8'h0A);
        step(1, 0, 1, 8'h5B, "load_out_same");
        step(0, 0, 1, 8'h00, "after_5B");
        step(0, 1, 1, 8'h00, "clear");
        step(0, 0, 1, 8'h00, "after_clear");
        step(1, 0, 0, 8'h77, "load_77");
        step(1, 1, 1, 8'h15, "load_clr_15");
        step(0, 0, 1, 8'h00, "after_load_clr");

        async_reset("reset_wrap");
        for (int i = 0; i < 256; i++)
            step(1, 0, 0, 8'h01, "load_01");
        step(0, 0, 1, 8'h00, "wrapped");
        chk1("wrapped_const", "count", irb.fetch_count, 8'h00);

        step(1, 0, 0, 8'hF0, "load_F0");
        step(1, 0, 1, 8'h33, "halt_ignore_33");
        step(0, 1, 1, 8'h00, "halt_ignore_clr");
        step(0, 0, 1, 8'h00, "halt_hold");
        chk1("halt_const", "opcode", {4'h0, irb.opcode}, 8'h0F);

        async_reset("reset_f7_pre");
        step(1, 0, 0, 8'hF7, "load_F7");
        step(0, 0, 1, 8'h00, "halted_F7");
        async_reset("reset_mid_halt");
        step(1, 0, 0, 8'h4C, "load_4C");
        step(0, 0, 1, 8'h00, "after_4C");
        chk1("after_4C_const", "opcode", {4'h0, irb.opcode}, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
